stage2: RTL
===========

STAGE2 -- requirements
Module: stage2

Interface
REQ-001 SHALL have parameter ROUND_CONST, default 32'h5A827999, the MD4 round-2 additive constant.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning upstream (stage1 result plus message block) is valid.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block can accept a job.
REQ-006 SHALL have ports a_in, b_in, c_in, d_in, input, 32 bits each, the chaining words from stage1.
REQ-007 SHALL have port x, input, 512 bits, the message block; word k is x[32k+31:32k], k=0..15.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning the results are valid.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning downstream (stage3) accepts the results.
REQ-010 SHALL have ports out_a, out_b, out_c, out_d, output, 32 bits each, the round-2 results.

Function
REQ-011 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE.
REQ-013 SHALL drive out_valid=1 only in DONE.
REQ-014 SHALL, on a rising edge with in_valid=1 in IDLE, load a_in..d_in into working registers A..D, latch x internally, clear the 4-bit step counter, and enter RUN.
REQ-015 SHALL ignore in_valid outside IDLE; there SHALL be no overlap of jobs.
REQ-016 SHALL, in RUN, perform exactly one step per clock edge.
REQ-017 SHALL compute each step as dest = rotl32(dest + G(p,q,r) + X[k] + ROUND_CONST, s), with all additions modulo 2^32.
REQ-018 SHALL compute G(p,q,r) = (p&q)|(p&r)|(q&r).
REQ-019 SHALL use rotl32 as a left circular rotate, so that bit 31 wraps to bit 0.
REQ-020 SHALL use this step order, for steps 0..15, as (dest,p,q,r,k,s): (A,B,C,D,0,3) (D,A,B,C,4,5) (C,D,A,B,8,9) (B,C,D,A,12,13), then the same four patterns with k+1, k+2 and k+3 for steps 4-7, 8-11 and 12-15 respectively. The k sequence is therefore 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
REQ-021 SHALL use the value of the destination register updated in the preceding step wherever that register appears as p, q or r.
REQ-022 SHALL, on the edge that completes step 15, enter DONE; out_valid SHALL rise exactly 16 edges after the accepting edge.
REQ-023 SHALL hold out_a..out_d equal to A..D, and SHALL keep them stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on an edge in DONE with out_ready=1, return to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-025 SHALL have a minimum job period of 18 cycles (accept, 16 RUN, 1 DONE) when out_ready is held at 1.
REQ-026 SHALL ignore out_ready outside DONE.
REQ-027 SHALL, if in_valid and out_ready are both high in DONE, only complete the output transfer; the new job is accepted no earlier than the next cycle in IDLE.
REQ-028 SHALL not let changes on x or a_in..d_in after acceptance affect the job in flight.

Reset
REQ-029 SHALL, while rst_n=0, immediately force IDLE, step counter 0 and A..D = 0, so that out_a..out_d = 0, out_valid = 0 and in_ready = 1.
REQ-030 SHALL, on reset asserted mid-RUN or in DONE, abort the job with no output produced.
REQ-031 SHALL, after reset deasserts, accept a new job on the first edge with in_valid=1.

Verification
REQ-032 SHALL cover: a_in=b_in=c_in=d_in=0, x=0, in_valid pulsed -> internal A after the first RUN edge = 32'hD413CCCA, and out_valid rises 16 edges after accept.
REQ-033 SHALL cover: a_in..d_in=67452301/efcdab89/98badcfe/10325476 and x equal to the stage1 bench block -> out_a..d equal to a bit-accurate software model of MD4 round 2.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and out_a..d are unchanged throughout, in_ready=0, and a second in_valid pulse is ignored.
REQ-035 SHALL cover: in_valid held at 1 continuously with out_ready=1 -> accepts occur exactly 18 cycles apart and each result matches the model.
REQ-036 SHALL cover: rst_n pulsed low at step 7 -> asynchronous zeroing of outputs with in_ready=1, no out_valid, and the next job's result is correct.
REQ-037 SHALL cover: a vector with sums exceeding 2^32 and words with bit 31 set -> correct modulo-2^32 wrap and rotation wrap versus the model.

Source files
------------

// File: rtl/stage2.sv
// MD4 round-2 engine: accepts one chaining state plus message block, runs the
// sixteen G-steps one per clock, then holds the result until downstream takes it.
module stage2 #(
  parameter logic [31:0] ROUND_CONST = 32'h5A827999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [31:0]    a_q, b_q, c_q, d_q;
  logic [511:0]   x_q;
  logic [3:0]     cnt_q;

  logic           load, step;
  logic [1:0]     pat;
  logic [3:0]     k;
  logic [31:0]    x_k, dest, p, q, r, g, sum, rot;

  assign load = (state_q == StIdle) && in_valid;
  assign step = (state_q == StRun);

  // Low two counter bits pick the rotating register pattern, high two pick
  // the word offset, so k walks 0,4,8,12,1,5,...
  assign pat = cnt_q[1:0];
  assign k   = {cnt_q[1:0], cnt_q[3:2]};
  assign x_k = x_q[{k, 5'b00000} +: 32];

  always_comb begin
    dest = a_q;
    p    = b_q;
    q    = c_q;
    r    = d_q;
    unique case (pat)
      2'd0: begin dest = a_q; p = b_q; q = c_q; r = d_q; end
      2'd1: begin dest = d_q; p = a_q; q = b_q; r = c_q; end
      2'd2: begin dest = c_q; p = d_q; q = a_q; r = b_q; end
      2'd3: begin dest = b_q; p = c_q; q = d_q; r = a_q; end
      default: ;
    endcase
  end

  assign g   = (p & q) | (p & r) | (q & r);
  assign sum = dest + g + x_k + ROUND_CONST;

  always_comb begin
    rot = sum;
    unique case (pat)
      2'd0: rot = {sum[28:0], sum[31:29]};
      2'd1: rot = {sum[26:0], sum[31:27]};
      2'd2: rot = {sum[22:0], sum[31:23]};
      2'd3: rot = {sum[18:0], sum[31:19]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (cnt_q == 4'd15) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      d_q     <= 32'd0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        c_q   <= c_in;
        d_q   <= d_in;
        x_q   <= x;
        cnt_q <= 4'd0;
      end else if (step) begin
        cnt_q <= cnt_q + 4'd1;
        unique case (pat)
          2'd0: a_q <= rot;
          2'd1: d_q <= rot;
          2'd2: c_q <= rot;
          2'd3: b_q <= rot;
          default: ;
        endcase
      end
    end
  end

  assign out_a = a_q;
  assign out_b = b_q;
  assign out_c = c_q;
  assign out_d = d_q;

endmodule
